// File: rtl/req_init_pkg.sv
// Shared types and defaults for the req/gnt requester block.
// Optional statistics counters are enabled with REQ_INITIATOR_STATS_EN.
package req_init_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_WAIT = 2'd1,
        GRANTED  = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam int DEF_LEN_W    = 4;
    localparam int DEF_TIMEOUT  = 16;
    localparam int DEF_IDLE_GAP = 2;
    localparam int STAT_W       = 16;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/req_init_timer.sv
// Loadable up/down counter with a terminal-count flag. Used by the
// requester both as the grant-timeout counter and the idle-gap counter.
module req_init_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load has priority over counting; inc has priority over dec.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/req_initiator.sv
// Requester end of the single-bit req/gnt handshake. Accepts a burst
// command, holds req until cmd_len+1 granted beats are counted, abandons
// after TIMEOUT consecutive ungranted cycles, then idles for IDLE_GAP.
// Define REQ_INITIATOR_STATS_EN to add saturating done/timeout counters.
module req_initiator
    import req_init_pkg::*;
#(
    parameter int LEN_W    = DEF_LEN_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             req,
    input  logic             gnt,
    output logic             busy,
    output logic [LEN_W:0]   beat_cnt,
    output logic             done,
    output logic             timeout
`ifdef REQ_INITIATOR_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_done_cnt,
    output logic [STAT_W-1:0] stat_timeout_cnt
`endif
);

    localparam int TO_W  = cnt_width(TIMEOUT);
    localparam int GAP_W = cnt_width(IDLE_GAP);
    localparam logic [TO_W-1:0]  TO_TERM  = TO_W'(TIMEOUT - 1);
    // GAP always lasts at least one cycle, so a zero gap loads the same as one.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic             beat;
    logic             starved;
    logic             last_beat;
    logic             expire;
    logic             to_tc;
    logic             gap_tc;

    // req is high exactly in REQ_WAIT/GRANTED, so it qualifies every beat.
    assign beat      = req & gnt;
    assign starved   = req & ~gnt;
    assign last_beat = beat && (beat_cnt == {1'b0, len});
    assign expire    = starved & to_tc;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Counts consecutive req-high/gnt-low cycles; any other cycle clears it.
    req_init_timer #(.W(TO_W)) u_grant_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (~starved),
        .load_val ('0),
        .inc      (starved),
        .dec      (1'b0),
        .term     (TO_TERM),
        .tc       (to_tc)
    );

    // Loaded on every release, counts down to zero while in GAP.
    req_init_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (last_beat | expire),
        .load_val (GAP_LOAD),
        .inc      (1'b0),
        .dec      ((state == GAP) && !gap_tc),
        .term     ('0),
        .tc       (gap_tc)
    );

    // Burst control FSM with registered req/done/timeout/beat_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            req      <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            // NOTE: every state register here uses <= so all of them update
            // from the same pre-edge values; a blocking write would leak the
            // new value into later lines of this block.
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len      <= cmd_len;
                        beat_cnt <= '0;
                        req      <= 1'b1;
                        state    <= REQ_WAIT;
                    end
                end
                REQ_WAIT, GRANTED: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + (LEN_W+1)'(1);
                    end
                    // Completion is checked first so it always wins over timeout.
                    if (last_beat) begin
                        req   <= 1'b0;
                        done  <= 1'b1;
                        state <= GAP;
                    end else if (expire) begin
                        req     <= 1'b0;
                        timeout <= 1'b1;
                        state   <= GAP;
                    end else begin
                        state <= gnt ? GRANTED : REQ_WAIT;
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REQ_INITIATOR_STATS_EN
    // Saturating event counters, bumped on the edge that raises each pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done_cnt    <= '0;
            stat_timeout_cnt <= '0;
        end else begin
            if (last_beat && stat_done_cnt != '1) begin
                stat_done_cnt <= stat_done_cnt + STAT_W'(1);
            end
            if (expire && stat_timeout_cnt != '1) begin
                stat_timeout_cnt <= stat_timeout_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_req_initiator.sv
// Self-checking bench for req_initiator: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_req_initiator;

    localparam int LEN_W    = 4;
    localparam int TIMEOUT  = 16;
    localparam int IDLE_GAP = 2;
    localparam int GAP_CYC  = (IDLE_GAP < 1) ? 1 : IDLE_GAP;

    localparam int G_RESP = 0;  // registered zero-wait responder
    localparam int G_ZERO = 1;  // gnt tied low
    localparam int G_DROP = 2;  // responder with a 3-cycle dropout after beat 2
    localparam int G_RAND = 3;  // random gnt and commands

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             req;
    logic             gnt = 1'b0;
    logic             busy;
    logic [LEN_W:0]   beat_cnt;
    logic             done;
    logic             timeout;
`ifdef REQ_INITIATOR_STATS_EN
    logic [15:0]      stat_done_cnt;
    logic [15:0]      stat_timeout_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state (burst-level bookkeeping, not the RTL's FSM).
    int m_req, m_prev_req, m_beats, m_target, m_run, m_gap, m_done, m_to;
    int m_stat_d, m_stat_t;

    // Per-scenario observations of the DUT.
    int sc_req_hi, sc_done, sc_to, sc_rise, sc_low, sc_min_gap;
    int prev_dut_req;
    int drop_left, low_left;

    always #5 clk = ~clk;

    req_initiator #(
        .LEN_W    (LEN_W),
        .TIMEOUT  (TIMEOUT),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .req       (req),
        .gnt       (gnt),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .done      (done),
        .timeout   (timeout)
`ifdef REQ_INITIATOR_STATS_EN
        ,
        .stat_done_cnt    (stat_done_cnt),
        .stat_timeout_cnt (stat_timeout_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_prev_req = 0; m_beats = 0; m_target = 0; m_run = 0;
        m_gap = 0; m_done = 0; m_to = 0; m_stat_d = 0; m_stat_t = 0;
        prev_dut_req = 0;
    endtask

    task automatic scen_reset();
        sc_req_hi = 0; sc_done = 0; sc_to = 0; sc_rise = 0; sc_low = 0;
        sc_min_gap = 1000;
    endtask

    // One clock edge of the reference model, from the inputs seen at the edge.
    task automatic model_edge();
        m_prev_req = m_req;
        m_done = 0;
        m_to = 0;
        if (m_req != 0) begin
            if (gnt) begin
                m_beats++;
                m_run = 0;
                if (m_beats == m_target) begin
                    m_req = 0; m_done = 1; m_gap = GAP_CYC;
                    if (m_stat_d < 65535) m_stat_d++;
                end
            end else begin
                m_run++;
                if (m_run == TIMEOUT) begin
                    m_req = 0; m_to = 1; m_gap = GAP_CYC; m_run = 0;
                    if (m_stat_t < 65535) m_stat_t++;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (cmd_valid) begin
            m_target = int'(cmd_len) + 1;
            m_beats = 0;
            m_run = 0;
            m_req = 1;
        end
    endtask

    task automatic compare();
        check("req", 32'(req), 32'(m_req));
        check("done", 32'(done), 32'(m_done));
        check("timeout", 32'(timeout), 32'(m_to));
        check("beat_cnt", 32'(beat_cnt), 32'(m_beats));
        check("cmd_ready", 32'(cmd_ready), 32'((m_req == 0 && m_gap == 0) ? 1 : 0));
        check("busy", 32'(busy), 32'((m_req != 0 || m_gap != 0) ? 1 : 0));
`ifdef REQ_INITIATOR_STATS_EN
        check("stat_done", 32'(stat_done_cnt), 32'(m_stat_d));
        check("stat_timeout", 32'(stat_timeout_cnt), 32'(m_stat_t));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        sc_req_hi += int'(req);
        sc_done   += int'(done);
        sc_to     += int'(timeout);
        if (req && prev_dut_req == 0) begin
            if (sc_rise > 0 && sc_low < sc_min_gap) sc_min_gap = sc_low;
            sc_rise++;
        end
        sc_low = req ? 0 : sc_low + 1;
        prev_dut_req = int'(req);
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                G_ZERO: gnt = 1'b0;
                G_DROP: begin
                    if (m_beats == 2 && drop_left > 0) begin
                        gnt = 1'b0;
                        drop_left--;
                    end else begin
                        gnt = (m_prev_req != 0);
                    end
                end
                G_RAND: begin
                    cmd_valid = ($urandom_range(0, 1) == 1);
                    cmd_len   = LEN_W'($urandom);
                    if (low_left > 0) begin
                        gnt = 1'b0;
                        low_left--;
                    end else if ($urandom_range(0, 29) == 0) begin
                        low_left = $urandom_range(5, 20);
                        gnt = 1'b0;
                    end else begin
                        gnt = ($urandom_range(0, 2) != 0);
                    end
                end
                default: gnt = (m_prev_req != 0);
            endcase
            step();
        end
    endtask

    // Issue one command for a single cycle, then run the responder.
    task automatic burst(input int len, input int mode, input int cycles);
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(len);
        run(1, mode);
        cmd_valid = 1'b0;
        run(cycles, mode);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        gnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        scen_reset();
        drop_left = 0;
        low_left = 0;

        // Reset state, observed while reset is held.
        #3;
        check("rst_req", 32'(req), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        apply_reset();
        run(2, G_RESP);

        // Zero-wait responder, cmd_len=3.
        scen_reset();
        burst(3, G_RESP, 10);
        check("zw_req_cycles", 32'(sc_req_hi), 32'd5);
        check("zw_done_pulses", 32'(sc_done), 32'd1);
        check("zw_timeouts", 32'(sc_to), 32'd0);
        check("zw_beat_cnt", 32'(beat_cnt), 32'd4);

        // gnt tied low: abandon after TIMEOUT cycles.
        scen_reset();
        burst(7, G_ZERO, TIMEOUT + 8);
        check("to_req_cycles", 32'(sc_req_hi), 32'(TIMEOUT));
        check("to_pulses", 32'(sc_to), 32'd1);
        check("to_done_pulses", 32'(sc_done), 32'd0);
        check("to_beat_cnt", 32'(beat_cnt), 32'd0);

        // cmd_len=5 with a 3-cycle gnt dropout after beat 2.
        scen_reset();
        drop_left = 3;
        burst(5, G_DROP, 16);
        check("drop_timeouts", 32'(sc_to), 32'd0);
        check("drop_done_pulses", 32'(sc_done), 32'd1);
        check("drop_beat_cnt", 32'(beat_cnt), 32'd6);

        // Back-to-back commands, cmd_valid held high, cmd_len=0.
        scen_reset();
        cmd_valid = 1'b1;
        cmd_len = '0;
        run(30, G_RESP);
        cmd_valid = 1'b0;
        run(8, G_RESP);
        check("b2b_min_gap_ok", 32'((sc_min_gap >= IDLE_GAP) ? 1 : 0), 32'd1);
        check("b2b_done_per_burst", 32'(sc_done), 32'(sc_rise));
        check("b2b_bursts", 32'((sc_rise >= 5) ? 1 : 0), 32'd1);

        // Asynchronous reset mid-GRANTED, then a normal 2-beat burst.
        scen_reset();
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(5);
        run(1, G_RESP);
        cmd_valid = 1'b0;
        run(3, G_RESP);
        check("mid_beat_cnt", 32'(beat_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", 32'(req), 32'd0);
        check("async_beat_cnt", 32'(beat_cnt), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_timeout", 32'(timeout), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        gnt = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
        scen_reset();
        burst(1, G_RESP, 8);
        check("post_rst_done", 32'(sc_done), 32'd1);
        check("post_rst_beat_cnt", 32'(beat_cnt), 32'd2);

        // Randomized traffic against the model.
        run(600, G_RAND);
        cmd_valid = 1'b0;
        run(TIMEOUT + 8, G_RESP);

`ifdef REQ_INITIATOR_STATS_EN
        // Three completions and two timeouts from a clean reset.
        apply_reset();
        for (int i = 0; i < 3; i++) burst(i, G_RESP, 8);
        for (int i = 0; i < 2; i++) burst(2, G_ZERO, TIMEOUT + 4);
        check("stat_done_final", 32'(stat_done_cnt), 32'd3);
        check("stat_timeout_final", 32'(stat_timeout_cnt), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_initiator.md
Name: req_initiator

Overview:
- Requester end of the single-bit req/gnt handshake; drives req toward a grant responder and consumes its gnt.
- The matching responder registers gnt from req, so gnt lags req by one clock.
- Accepts a burst command from upstream, holds req until the requested number of granted beats is counted, then releases.
- Enforces a grant timeout and a minimum idle gap between requests.

Parameters:
- LEN_W, 4: width of cmd_len; burst length is cmd_len+1 beats (1..2^LEN_W).
- TIMEOUT, 16: consecutive req-high/gnt-low cycles before the request is abandoned (≥1).
- IDLE_GAP, 2: cycles req is held low after any release before the next command is accepted (≥0).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  upstream command present
- cmd_ready  output  1  block accepts command (combinational: state==IDLE)
- cmd_len  input  LEN_W  beats minus one, sampled on accept
- req  output  1  request to responder, registered
- gnt  input  1  grant from responder
- busy  output  1  state != IDLE
- beat_cnt  output  LEN_W+1  granted beats counted in current burst
- done  output  1  one-cycle pulse, burst completed
- timeout  output  1  one-cycle pulse, burst abandoned

Behaviour:
- Reset, asynchronous, active-low:
  - Reset values: req=0, done=0, timeout=0, beat_cnt=0, busy=0, state IDLE, all counters 0.
  - Assertion mid-burst drops req immediately and does not pulse done or timeout.
- A beat is counted on any rising edge where req==1 && gnt==1. gnt is ignored whenever req==0, so the trailing gnt after a release is not counted.
- States:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid: latch len=cmd_len, clear beat_cnt, set req<=1, go REQ_WAIT.
  - REQ_WAIT:
    - req=1.
    - gnt==1 sampled: count beat, clear timeout counter, go GRANTED.
    - gnt==0 sampled: timeout counter +1.
    - Counter reaching TIMEOUT: req<=0, timeout<=1 for one cycle, go GAP.
  - GRANTED:
    - req=1; each gnt==1 edge counts a beat.
    - gnt drops before completion: return to REQ_WAIT with beat_cnt preserved and a fresh timeout count.
  - Completion:
    - The edge that counts beat len+1 sets req<=0 and done<=1 for one cycle, then goes to GAP.
    - Completion and the timeout threshold on the same edge: completion wins, no timeout pulse.
  - GAP:
    - Hold for IDLE_GAP cycles, then IDLE.
    - IDLE_GAP=0 goes straight to IDLE on the next edge.
    - cmd_valid is ignored here (cmd_ready=0).
- Latency: req rises the cycle after acceptance.
  - Against a zero-wait registered responder, req stays high exactly cmd_len+2 cycles.
  - done rises on the same edge req falls.
- beat_cnt holds its final value until the next accept.
- cmd_len=all-ones gives 2^LEN_W beats; beat_cnt width LEN_W+1 avoids wrap.
- A single-cycle gnt glitch counts as exactly one beat.

Optional Feature:
- Macro: REQ_INITIATOR_STATS_EN.
- Defined:
  - Adds outputs stat_done_cnt[15:0] and stat_timeout_cnt[15:0], incremented on each done/timeout pulse.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package req_init_pkg:
  - state enum {IDLE, REQ_WAIT, GRANTED, GAP}
  - default constants for LEN_W, TIMEOUT, IDLE_GAP
  - stat counter width
- One natural sub-module: req_init_timer.
  - Loadable up/down counter with a terminal-count flag.
  - Instantiated twice: grant timeout and idle gap.

Test Plan:
- Zero-wait responder, cmd_len=3: req high 5 cycles, beat_cnt ends at 4, done pulses once on the edge req falls, no timeout.
- gnt tied 0, TIMEOUT=16: req high for 16 counted cycles, then drops. timeout pulses once, beat_cnt=0, cmd_ready returns after IDLE_GAP=2 low cycles.
- cmd_len=5 with gnt dropped for 3 cycles after beat 2: back to REQ_WAIT, no timeout, total counted beats=6, done once.
- Back-to-back cmd_valid held high, cmd_len=0: req pulses separated by ≥2 low cycles; each burst counts 1 beat; the post-release gnt never counted.
- rst_n asserted asynchronously mid-GRANTED (beat_cnt=2): req, done, timeout, beat_cnt go to 0 without waiting for a clock edge. After release, a new cmd_len=1 completes normally with 2 beats.
- With REQ_INITIATOR_STATS_EN: 3 completions + 2 timeouts leave stat_done_cnt=3 and stat_timeout_cnt=2.
